spi_master_px: RTL

- Parametrised SPI master, successor to the fixed 8-bit, mode-0-only SPI block.
- Generalises word width, slave-select count and SCLK rate; adds all four CPOL/CPHA modes, LSB-first option and a start/ready/rx_valid handshake.
- Sits between a host-side register/FSM layer and external SPI pins; one word per transfer.

---
 rtl/spi_master_px.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_px.sv
// Purpose : parametrised SPI master, one DATA_W-bit word per transfer, all CPOL/CPHA modes.
// Latency : rx_valid pulses (2*DATA_W+2)*H+1 clk cycles after the accepting start edge, H=clk_div+1.
// Backpr. : start is taken only while ready=1; a start seen while busy is dropped, never queued.
//
// Ports:
//   clk, rstn              system clock, async active-low reset
//   start / ready / busy   request handshake; ready only in IDLE, busy for the whole transfer
//   tx_data, ss_sel, cpol, cpha, lsb_first, clk_div
//                          transfer settings, all captured on the accepted start
//   rx_data / rx_valid     received word, valid pulse for one cycle when it updates
//   sclk, mosi, miso, ss_n SPI pins (ss_n active low, one per slave)

module spi_master_px #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8,
   localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   output logic              ready,
   output logic              busy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int ECW = $clog2(2 * DATA_W);
   localparam logic [ECW-1:0] LAST_E = ECW'(2 * DATA_W - 1);

   // S_SEL is the first cycle of the setup phase: it asserts the slave select
   // and the first data bit, then S_SETUP waits one half-period before the
   // first SCLK edge.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_SETUP = 3'd2,
      S_XFER  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic [SEL_W-1:0]  ss_sel_q;
   logic              cpol_q;
   logic              cpha_q;
   logic              lsb_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  hcnt;     // counts 0..div_q, so H=2^DIV_W never overflows
   logic [ECW-1:0]    ecnt;     // edges already issued; even value means next edge is leading

   logic [NUM_SS-1:0] ss_mask;
   logic              do_sample;
   logic              do_advance;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_next;
   logic              mosi_next;

   // An out-of-range slave index simply matches no select line.
   always_comb begin
      ss_mask = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         ss_mask[i] = (32'(ss_sel_q) != i);
      end
   end

   // cpha=0: sample on leading edges, shift on trailing edges except the last.
   // cpha=1: shift on leading edges except the first, sample on trailing edges.
   always_comb begin
      do_sample  = 1'b0;
      do_advance = 1'b0;
      if (cpha_q) begin
         do_sample  = ecnt[0];
         do_advance = !ecnt[0] && (ecnt != '0);
      end else begin
         do_sample  = !ecnt[0];
         do_advance = ecnt[0] && (ecnt != LAST_E);
      end
   end

   // Shift directions keep rx and tx words in the same bit order.
   always_comb begin
      rx_next   = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
      tx_next   = lsb_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
      mosi_next = lsb_q ? tx_sh[1] : tx_sh[DATA_W-2];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         busy     <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= '1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         ss_sel_q <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         div_q    <= '0;
         hcnt     <= '0;
         ecnt     <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               sclk <= cpol;
               if (start) begin
                  tx_sh    <= tx_data;
                  ss_sel_q <= ss_sel;
                  cpol_q   <= cpol;
                  cpha_q   <= cpha;
                  lsb_q    <= lsb_first;
                  div_q    <= clk_div;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_SEL;
               end
            end

            S_SEL: begin
               ss_n  <= ss_mask;
               mosi  <= lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
               sclk  <= cpol_q;
               hcnt  <= '0;
               state <= S_SETUP;
            end

            S_SETUP: begin
               if (hcnt == div_q) begin
                  hcnt  <= '0;
                  ecnt  <= '0;
                  state <= S_XFER;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end

            S_XFER: begin
               if (hcnt == div_q) begin
                  hcnt <= '0;
                  sclk <= !sclk;
                  ecnt <= ecnt + 1'b1;
                  // miso is taken in the same cycle the edge is issued
                  if (do_sample) begin
                     rx_sh <= rx_next;
                  end
                  if (do_advance) begin
                     tx_sh <= tx_next;
                     mosi  <= mosi_next;
                  end
                  if (ecnt == LAST_E) begin
                     state <= S_HOLD;
                  end
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end

            S_HOLD: begin
               if (hcnt == div_q) begin
                  ss_n     <= '1;
                  rx_data  <= rx_sh;
                  rx_valid <= 1'b1;
                  ready    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               ss_n  <= '1;
            end
         endcase
      end
   end

endmodule
